// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_CNTW         = 4;

    // Read owner of the access issued in the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DL   = 2'd2
    } owner_e;

    // Winner of the single memory slot in the current cycle.
    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_IF   = 2'd1,
        SLOT_DL   = 2'd2,
        SLOT_WB   = 2'd3
    } slot_e;

    // Per-byte select between forwarded store bytes and memory bytes.
    function automatic logic [31:0] byte_merge(input logic [3:0]  mask,
                                               input logic [31:0] fwd,
                                               input logic [31:0] mem);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = mask[k] ? fwd[8*k +: 8] : mem[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_wbuf.sv
// One-entry posted store buffer with load-forwarding snapshot.
module mem_wbuf
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic [29:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_strb,
    output logic        valid,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic [3:0]  strb,
    input  logic        cap,
    input  logic [29:0] cmp_addr,
    output logic [3:0]  fwd_mask,
    output logic [31:0] fwd_data
);

    logic        valid_q, valid_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic [3:0]  fwd_mask_q, fwd_mask_d;
    logic [31:0] fwd_data_q, fwd_data_d;
    logic        hit;

    assign hit = valid_q & (addr_q == cmp_addr);

    // A load in the same cycle as a drain wins: the drain already used the old contents.
    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = ld_addr;
            data_d  = ld_data;
            strb_d  = ld_strb;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (cap) begin
            fwd_mask_d = hit ? strb_q : 4'b0000;
            fwd_data_d = data_q;
        end
    end

    // Buffer and snapshot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign valid    = valid_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign strb     = strb_q;
    assign fwd_mask = fwd_mask_q;
    assign fwd_data = fwd_data_q;

endmodule

// File: rtl/mem1port_arbiter.sv
// Fetch / load-store arbiter in front of one single-port memory.
//   owner    | meaning
//   OWN_IDLE | no read issued last cycle (or write-buffer drain)
//   OWN_IF   | last cycle's slot was a fetch read
//   OWN_DL   | last cycle's slot was a data load
module mem1port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CNTW         = DEF_CNTW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_ready,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_rresp,
    input  logic [31:0] m_rdata
);

    localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

    logic            wb_valid;
    logic [29:0]     wb_addr;
    logic [31:0]     wb_data;
    logic [3:0]      wb_strb;
    logic [3:0]      fwd_mask;
    logic [31:0]     fwd_data;
    slot_e           slot;
    owner_e          owner_q, owner_d;
    logic [CNTW-1:0] starve_q, starve_d;
    logic            dl_cand, st_req, st_acc, starved, wb_block;
    logic            i_resp, d_resp;
    logic [31:0]     i_rdata_q, d_rdata_q, d_merged;

    assign dl_cand  = d_req & ~d_we;
    assign st_req   = d_req & d_we;
    assign starved  = (starve_q == LIMIT);
    assign wb_block = wb_valid & st_req;

    // Slot arbitration; the slot is withheld while reset is asserted.
    always_comb begin
        slot = SLOT_NONE;
        if (reset) begin
            slot = SLOT_NONE;
        end else if (starved) begin
            if (i_req)         slot = SLOT_IF;
            else if (dl_cand)  slot = SLOT_DL;
            else if (wb_valid) slot = SLOT_WB;
        end else if (wb_block) begin
            // a pending store implies no load, so the buffer always wins here
            slot = SLOT_WB;
        end else begin
            if (dl_cand)       slot = SLOT_DL;
            else if (i_req)    slot = SLOT_IF;
            else if (wb_valid) slot = SLOT_WB;
        end
    end

    assign st_acc = st_req & ~reset & (~wb_valid | (slot == SLOT_WB));
    assign i_gnt  = (slot == SLOT_IF);
    assign d_gnt  = (slot == SLOT_DL) | st_acc;

    // Memory drive from the slot winner.
    always_comb begin
        m_ready = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        case (slot)
            SLOT_IF: begin
                m_ready = 1'b1;
                m_addr  = i_addr;
            end
            SLOT_DL: begin
                m_ready = 1'b1;
                m_addr  = d_addr;
            end
            SLOT_WB: begin
                m_ready = 1'b1;
                m_we    = 1'b1;
                m_addr  = wb_addr;
                m_wdata = wb_data;
                m_wstrb = wb_strb;
            end
            default: m_ready = 1'b0;
        endcase
    end

    // Next owner and starvation count.
    always_comb begin
        owner_d  = OWN_IDLE;
        starve_d = starve_q;
        case (slot)
            SLOT_IF: owner_d = OWN_IF;
            SLOT_DL: owner_d = OWN_DL;
            default: owner_d = OWN_IDLE;
        endcase
        if (!i_req || i_gnt) starve_d = '0;
        else if (starve_q != LIMIT) starve_d = starve_q + CNTW'(1);
    end

    assign i_resp   = m_rresp & (owner_q == OWN_IF);
    assign d_resp   = m_rresp & (owner_q == OWN_DL);
    assign d_merged = byte_merge(fwd_mask, fwd_data, m_rdata);

    // Owner, starvation counter and held response data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q   <= OWN_IDLE;
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (i_resp) i_rdata_q <= m_rdata;
            if (d_resp) d_rdata_q <= d_merged;
        end
    end

    // Data is presented in the response cycle and held afterwards.
    assign i_rvalid = i_resp;
    assign i_rdata  = i_resp ? m_rdata : i_rdata_q;
    assign d_rvalid = d_resp;
    assign d_rdata  = d_resp ? d_merged : d_rdata_q;

    mem_wbuf u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (st_acc),
        .drain    (slot == SLOT_WB),
        .ld_addr  (d_addr),
        .ld_data  (d_wdata),
        .ld_strb  (d_wstrb),
        .valid    (wb_valid),
        .addr     (wb_addr),
        .data     (wb_data),
        .strb     (wb_strb),
        .cap      (slot == SLOT_DL),
        .cmp_addr (d_addr),
        .fwd_mask (fwd_mask),
        .fwd_data (fwd_data)
    );

endmodule
